// File: rtl/alu_pipe.sv
`timescale 1ns/1ps
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes, synchronous flush and a ZVN flag register.
// S1 registers accepted operands; S2 computes from S1, holds the result until it retires, then updates flags.
module alu_pipe #(
   parameter int DATA_W = 16,
   parameter int LANE_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        out_opcode,
   output logic [2:0]        flags
);

   localparam int SHAMT_W = $clog2(DATA_W);
   localparam int N_BYTES = DATA_W / 8;
   localparam int N_LANES = DATA_W / LANE_W;

   localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [LANE_W-1:0] L_MAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] L_MIN = {1'b1, {(LANE_W-1){1'b0}}};

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_RED    = 4'd3;
   localparam logic [3:0] OP_SLL    = 4'd4;
   localparam logic [3:0] OP_SRA    = 4'd5;
   localparam logic [3:0] OP_ROR    = 4'd6;
   localparam logic [3:0] OP_PADDSB = 4'd7;
   localparam logic [3:0] OP_LWA    = 4'd8;
   localparam logic [3:0] OP_SWA    = 4'd9;
   localparam logic [3:0] OP_SRL    = 4'd10;
   localparam logic [3:0] OP_PASSB  = 4'd11;

   logic              s1_valid;
   logic [3:0]        s1_opcode;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic              s2_valid;
   logic              s2_we;
   logic [2:0]        s2_flags;

   logic adv1, adv2, accept, retire;

   // Handshake: a transfer happens on an edge where valid && ready. A stage advances when it
   // is empty or its successor advances; in_ready never looks at in_valid, and flush blocks intake.
   assign adv2     = !s2_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1 && !flush;
   assign accept   = in_valid && in_ready;
   assign retire   = s2_valid && out_ready && !flush;
   assign out_valid = s2_valid;

   logic [DATA_W-1:0]   add_sum, sub_diff, add_sat, sub_sat;
   logic                add_ovf, sub_ovf;
   logic [SHAMT_W-1:0]  shamt;
   logic [2*DATA_W-1:0] rot_dbl;
   logic [DATA_W-1:0]   sra_res, red_acc, paddsb_res;
   logic [LANE_W-1:0]   lane_sum;
   logic                lane_ovf;

   assign add_sum  = s1_a + s1_b;
   assign sub_diff = s1_a - s1_b;
   assign add_ovf  = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (add_sum[DATA_W-1] != s1_a[DATA_W-1]);
   assign sub_ovf  = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) && (sub_diff[DATA_W-1] != s1_a[DATA_W-1]);
   // A wrapped negative sum means true overflow was positive, so clamp high (and vice versa).
   assign add_sat  = add_ovf ? (add_sum[DATA_W-1] ? S_MAX : S_MIN) : add_sum;
   assign sub_sat  = sub_ovf ? (sub_diff[DATA_W-1] ? S_MAX : S_MIN) : sub_diff;
   assign shamt    = s1_b[SHAMT_W-1:0];
   assign rot_dbl  = {s1_a, s1_a} >> shamt;
   assign sra_res  = $signed(s1_a) >>> shamt;

   always_comb begin
      red_acc = '0;
      for (int i = 0; i < N_BYTES; i++) begin
         red_acc = red_acc + DATA_W'($signed(s1_a[8*i +: 8])) + DATA_W'($signed(s1_b[8*i +: 8]));
      end
   end

   always_comb begin
      paddsb_res = '0;
      lane_sum   = '0;
      lane_ovf   = 1'b0;
      for (int l = 0; l < N_LANES; l++) begin
         lane_sum = s1_a[l*LANE_W +: LANE_W] + s1_b[l*LANE_W +: LANE_W];
         lane_ovf = (s1_a[l*LANE_W+LANE_W-1] == s1_b[l*LANE_W+LANE_W-1]) &&
                    (lane_sum[LANE_W-1] != s1_a[l*LANE_W+LANE_W-1]);
         if (lane_ovf) paddsb_res[l*LANE_W +: LANE_W] = lane_sum[LANE_W-1] ? L_MAX : L_MIN;
         else          paddsb_res[l*LANE_W +: LANE_W] = lane_sum;
      end
   end

   logic [DATA_W-1:0] nxt_result;
   logic              nxt_we, nxt_v, nxt_n_en;
   logic [2:0]        nxt_flags;

   always_comb begin
      nxt_result = '0;
      nxt_we     = 1'b0;
      nxt_v      = 1'b0;
      nxt_n_en   = 1'b0;
      case (s1_opcode)
         OP_ADD:    begin nxt_result = add_sat; nxt_we = 1'b1; nxt_v = add_ovf; nxt_n_en = 1'b1; end
         OP_SUB:    begin nxt_result = sub_sat; nxt_we = 1'b1; nxt_v = sub_ovf; nxt_n_en = 1'b1; end
         OP_XOR:    begin nxt_result = s1_a ^ s1_b; nxt_we = 1'b1; end
         OP_RED:    nxt_result = red_acc;
         OP_SLL:    begin nxt_result = s1_a << shamt; nxt_we = 1'b1; end
         OP_SRA:    begin nxt_result = sra_res; nxt_we = 1'b1; end
         OP_ROR:    begin nxt_result = rot_dbl[DATA_W-1:0]; nxt_we = 1'b1; end
         OP_PADDSB: nxt_result = paddsb_res;
         OP_LWA,
         OP_SWA:    nxt_result = add_sum;
         OP_SRL:    begin nxt_result = s1_a >> shamt; nxt_we = 1'b1; end
         OP_PASSB:  nxt_result = s1_b;
         default:   nxt_result = '0;
      endcase
      nxt_flags = {nxt_result == '0, nxt_v, nxt_n_en & nxt_result[DATA_W-1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_opcode <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
      end else begin
         if (flush)     s1_valid <= 1'b0;
         else if (adv1) s1_valid <= in_valid;
         if (accept) begin
            s1_opcode <= opcode;
            s1_a      <= a;
            s1_b      <= b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         result     <= '0;
         out_opcode <= '0;
         s2_we      <= 1'b0;
         s2_flags   <= '0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result     <= nxt_result;
            out_opcode <= s1_opcode;
            s2_we      <= nxt_we;
            s2_flags   <= nxt_flags;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                flags <= 3'b000;
      else if (retire && s2_we)  flags <= s2_flags;
   end

endmodule

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
// Bench for alu_pipe: directed and random ops through a scoreboard, plus a 32-bit/8-bit-lane instance.
module tb_alu_pipe;
  localparam int DW = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] opcode, out_opcode;
  logic [DW-1:0] a, b, result;
  logic [2:0] flags;
  logic man_ready, rnd_ready, rnd_bit;

  logic p_in_valid, p_in_ready, p_out_valid;
  logic [3:0] p_opcode, p_out_opcode;
  logic [31:0] p_a, p_b, p_result;
  logic [2:0] p_flags;

  assign out_ready = rnd_ready ? rnd_bit : man_ready;

  alu_pipe #(.DATA_W(DW), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_opcode(out_opcode), .flags(flags)
  );

  alu_pipe #(.DATA_W(32), .LANE_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .opcode(p_opcode), .a(p_a), .b(p_b), .out_valid(p_out_valid), .out_ready(1'b1),
    .result(p_result), .out_opcode(p_out_opcode), .flags(p_flags)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [3:0]    op_q[$];
  logic [3:0]    fl_q[$];   // {write_enable, Z, V, N}
  logic [2:0]    model_flags = 3'b000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    op_q.delete();
    fl_q.delete();
  endtask

  // reference model: plain integer arithmetic on the op definitions
  function automatic void model(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                                output logic [DW-1:0] r, output logic [3:0] f);
    longint smax = (longint'(1) << (DW-1)) - 1;
    longint smin = -(longint'(1) << (DW-1));
    longint lmax = (longint'(1) << (LW-1)) - 1;
    longint lmin = -(longint'(1) << (LW-1));
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    int sh = int'(y % DW);
    longint s, la, lb;
    logic v = 1'b0;
    logic we = 1'b0;
    logic zonly = 1'b0;
    r = '0;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sx + sy : sx - sy;
        v = (s > smax) || (s < smin);
        if (s > smax) s = smax;
        if (s < smin) s = smin;
        r = s[DW-1:0];
        we = 1'b1;
      end
      4'd2: begin r = x ^ y; we = 1'b1; zonly = 1'b1; end
      4'd3: begin
        s = 0;
        for (int i = 0; i < DW/8; i++)
          s += longint'($signed(x[8*i +: 8])) + longint'($signed(y[8*i +: 8]));
        r = s[DW-1:0];
      end
      4'd4: begin r = x << sh; we = 1'b1; zonly = 1'b1; end
      4'd5: begin s = sx >>> sh; r = s[DW-1:0]; we = 1'b1; zonly = 1'b1; end
      4'd6: begin
        for (int i = 0; i < DW; i++) r[i] = x[(i + sh) % DW];
        we = 1'b1; zonly = 1'b1;
      end
      4'd7: begin
        for (int l = 0; l < DW/LW; l++) begin
          la = longint'(x[l*LW +: LW]);
          lb = longint'(y[l*LW +: LW]);
          if (la > lmax) la -= (longint'(1) << LW);
          if (lb > lmax) lb -= (longint'(1) << LW);
          s = la + lb;
          if (s > lmax) s = lmax;
          if (s < lmin) s = lmin;
          r[l*LW +: LW] = s[LW-1:0];
        end
      end
      4'd8, 4'd9: r = x + y;
      4'd10: begin r = x >> sh; we = 1'b1; zonly = 1'b1; end
      4'd11: r = y;
      default: r = '0;
    endcase
    if (!we)        f = 4'b0000;
    else if (zonly) f = {1'b1, r == '0, 2'b00};
    else            f = {1'b1, r == '0, v, r[DW-1]};
  endfunction

  // driver tasks: called just after a rising edge, return just after the accepting edge
  task automatic issue_core(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input logic [DW-1:0] r, input logic [3:0] f);
    in_valid = 1'b1; opcode = op; a = x; b = y;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(r); op_q.push_back(op); fl_q.push_back(f);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", op);
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] r;
    logic [3:0] f;
    model(op, x, y, r, f);
    issue_core(op, x, y, r, f);
  endtask

  task automatic issue_k(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [DW-1:0] r, input logic [3:0] f);
    issue_core(op, x, y, r, f);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    clear_sb();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic p_run(input string name, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r);
    p_in_valid = 1'b1; p_opcode = op; p_a = x; p_b = y;
    @(negedge clk);
    check({name, "_in_ready"}, p_in_ready, 1'b1);
    @(posedge clk); #1;
    p_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, p_out_valid, 1'b1);
    check({name, "_result"}, p_result, r);
    check({name, "_opcode"}, p_out_opcode, op);
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return DW'($urandom_range(0, 15));
      default: return DW'($urandom());
    endcase
  endfunction

  // monitor: flags every cycle, result/opcode on each retire
  always @(negedge clk) begin
    check("flags", flags, model_flags);
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire: result %0h with empty expected queue", result);
      end else begin
        logic [DW-1:0] er;
        logic [3:0] eo, ef;
        er = exp_q.pop_front(); eo = op_q.pop_front(); ef = fl_q.pop_front();
        check("result", result, er);
        check("out_opcode", out_opcode, eo);
        if (ef[3]) model_flags = ef[2:0];
      end
    end
  end

  initial begin : main
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
    man_ready = 1'b1; rnd_ready = 1'b0;
    p_in_valid = 1'b0; p_opcode = '0; p_a = '0; p_b = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 16'h0000);
    check("reset_out_opcode", out_opcode, 4'h0);
    check("reset_flags", flags, 3'b000);
    rst_n = 1'b1;

    // basic ADD and two-cycle latency
    issue_k(4'd0, 16'h0003, 16'h0004, 16'h0007, 4'b1000);
    @(negedge clk);
    check("add_lat_s1", out_valid, 1'b0);
    @(negedge clk);
    check("add_lat_s2", out_valid, 1'b1);
    check("add_result", result, 16'h0007);
    idle(1);

    // saturation
    issue_k(4'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1010);
    issue_k(4'd1, 16'h8000, 16'h0001, 16'h8000, 4'b1011);
    issue_k(4'd1, 16'h1234, 16'h1234, 16'h0000, 4'b1100);
    // PADDSB and RED leave flags alone
    issue_k(4'd7, 16'h7777, 16'h1111, 16'h7777, 4'b0000);
    issue_k(4'd3, 16'h0102, 16'hFF01, 16'h0003, 4'b0000);
    idle(4);
    @(negedge clk);
    check("flags_after_paddsb_red", flags, 3'b100);
    idle(1);
    issue_k(4'd5, 16'h8000, 16'h000F, 16'hFFFF, 4'b1000);
    issue_k(4'd6, 16'h0001, 16'h0001, 16'h8000, 4'b1000);
    issue_k(4'd10, 16'h8000, 16'h000F, 16'h0001, 4'b1000);
    idle(4);

    // back-pressure
    man_ready = 1'b0;
    fork
      begin
        issue_k(4'd2, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b1000);
        issue_k(4'd2, 16'h1234, 16'h0001, 16'h1235, 4'b1000);
        issue_k(4'd2, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b1000);
        issue_k(4'd2, 16'hABCD, 16'hABCD, 16'h0000, 4'b1100);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_result", result, 16'h0FF0);
        repeat (2) begin
          @(negedge clk);
          check("bp_hold_valid", out_valid, 1'b1);
          check("bp_hold_result", result, 16'h0FF0);
        end
        @(posedge clk); #1;
        man_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("bp_stream_valid", out_valid, 1'b1);
        end
      end
    join
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_final_flags", flags, 3'b100);
    check("bp_drained", out_valid, 1'b0);
    idle(1);

    // flush with ADD in S2 and SLL in S1
    man_ready = 1'b0;
    issue_k(4'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1010);
    issue_k(4'd4, 16'h0001, 16'h0003, 16'h0008, 4'b1000);
    man_ready = 1'b1;
    flush_pulse();
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_flags", flags, 3'b100);
    idle(1);

    // reset mid-stream
    man_ready = 1'b0;
    issue(4'd0, 16'h0001, 16'h0001);
    issue(4'd2, 16'h0001, 16'h0002);
    rst_n = 1'b0;
    clear_sb();
    model_flags = 3'b000;
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_flags", flags, 3'b000);
    idle(2);
    rst_n = 1'b1;
    man_ready = 1'b1;

    // random traffic with random back-pressure and occasional flush
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 24) == 0) flush_pulse();
    end
    rnd_ready = 1'b0;
    man_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    check("drain_empty", exp_q.size(), 0);

    // 32-bit data, 8-bit lanes
    p_run("w32_add_sat", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF);
    check("w32_add_flags", p_flags, 3'b010);
    p_run("w32_paddsb", 4'd7, 32'h0000_007F, 32'h0000_0001, 32'h0000_007F);
    p_run("w32_sll31", 4'd4, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
